// File: rtl/ecdsa_pkg.sv
// Shared types and defaults for the ECDSA point-multiplication datapath.
package ecdsa_pkg;

    localparam int ECC_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

    function automatic logic [1:0] idToOneHot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester the priority pointer names.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer names whichever requester did not just win.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/ecc_mult_sched.sv
// Shares one scalar multiplier between the sign (r=0) and verify (r=1)
// requesters, one operation at a time, with a timeout abort.
module ecc_mult_sched
    import ecdsa_pkg::*;
#(
    parameter int W       = ECC_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0][W-1:0] req_k,
    input  logic [1:0][W-1:0] req_px,
    input  logic [1:0][W-1:0] req_py,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [W-1:0]      rsp_rx,
    output logic [W-1:0]      rsp_ry,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [W-1:0]      mul_k,
    output logic [W-1:0]      mul_px,
    output logic [W-1:0]      mul_py,
    input  logic              mul_done,
    input  logic [W-1:0]      mul_rx,
    input  logic [W-1:0]      mul_ry,
    output logic              mul_abort
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_e  state_q;
    logic          grantId_q;
    logic [CW-1:0] timeoutCnt_q;
    logic [CW-1:0] timeoutCnt_d;
    logic [1:0]    rspValid_q;
    logic [W-1:0]  rspRx_q;
    logic [W-1:0]  rspRy_q;
    logic          rspErr_q;
    logic          mulStart_q;
    logic          mulAbort_q;
    logic [W-1:0]  mulK_q;
    logic [W-1:0]  mulPx_q;
    logic [W-1:0]  mulPy_q;
    logic [1:0]    grant;
    logic          inIdle;

    assign inIdle       = (state_q == IDLE);
    assign timeoutCnt_d = timeoutCnt_q + CW'(1);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (inIdle),
        .grant   (grant)
    );

    assign req_ready = inIdle ? grant : 2'b00;
    assign rsp_valid = rspValid_q;
    assign rsp_rx    = rspRx_q;
    assign rsp_ry    = rspRy_q;
    assign rsp_err   = rspErr_q;
    assign mul_start = mulStart_q;
    assign mul_abort = mulAbort_q;
    assign mul_k     = mulK_q;
    assign mul_px    = mulPx_q;
    assign mul_py    = mulPy_q;

    // The timeout fires on the cycle the counter steps onto TIMEOUT-1, so the
    // abort pulse lands exactly TIMEOUT cycles after mul_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grantId_q    <= 1'b0;
            timeoutCnt_q <= '0;
            rspValid_q   <= 2'b00;
            rspRx_q      <= '0;
            rspRy_q      <= '0;
            rspErr_q     <= 1'b0;
            mulStart_q   <= 1'b0;
            mulAbort_q   <= 1'b0;
            mulK_q       <= '0;
            mulPx_q      <= '0;
            mulPy_q      <= '0;
        end else begin
            mulStart_q <= 1'b0;
            mulAbort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grantId_q  <= grant[1];
                        mulK_q     <= req_k[grant[1]];
                        mulPx_q    <= req_px[grant[1]];
                        mulPy_q    <= req_py[grant[1]];
                        mulStart_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timeoutCnt_q <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    timeoutCnt_q <= timeoutCnt_d;
                    if (mul_done) begin
                        rspRx_q    <= mul_rx;
                        rspRy_q    <= mul_ry;
                        rspErr_q   <= 1'b0;
                        rspValid_q <= idToOneHot(grantId_q);
                        state_q    <= RESP;
                    end else if (timeoutCnt_d == CNT_LAST) begin
                        mulAbort_q <= 1'b1;
                        rspRx_q    <= '0;
                        rspRy_q    <= '0;
                        rspErr_q   <= 1'b1;
                        rspValid_q <= idToOneHot(grantId_q);
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grantId_q]) begin
                        rspValid_q <= 2'b00;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_mult_sched.sv
// Directed bench for ecc_mult_sched: a behavioural multiplier returning
// (k+px, k+py) plus a queue of expected responses.
module tb_ecc_mult_sched;
    import ecdsa_pkg::*;

    localparam int W       = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic         id;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][W-1:0] req_k;
    logic [1:0][W-1:0] req_px;
    logic [1:0][W-1:0] req_py;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [W-1:0]      rsp_rx;
    logic [W-1:0]      rsp_ry;
    logic              rsp_err;
    logic              mul_start;
    logic [W-1:0]      mul_k;
    logic [W-1:0]      mul_px;
    logic [W-1:0]      mul_py;
    logic              mul_done;
    logic [W-1:0]      mul_rx;
    logic [W-1:0]      mul_ry;
    logic              mul_abort;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   startCount = 0;
    int   abortCount = 0;
    int   lastStart = 0;
    int   lastAbort = 0;
    logic modelEnable = 1'b1;
    int   modelLatency = 5;
    logic modelBusy;
    int   modelCnt;
    logic [W-1:0] mK, mPx, mPy;
    int   startBefore;
    int   abortBefore;

    always #5 clk = ~clk;

    ecc_mult_sched #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_k     (req_k),
        .req_px    (req_px),
        .req_py    (req_py),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rx    (rsp_rx),
        .rsp_ry    (rsp_ry),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_k     (mul_k),
        .mul_px    (mul_px),
        .mul_py    (mul_py),
        .mul_done  (mul_done),
        .mul_rx    (mul_rx),
        .mul_ry    (mul_ry),
        .mul_abort (mul_abort)
    );

    // Multiplier stand-in: done pulses modelLatency cycles after mul_start.
    always @(posedge clk) begin
        if (rst) begin
            modelBusy <= 1'b0;
            modelCnt  <= 0;
            mul_done  <= 1'b0;
            mul_rx    <= '0;
            mul_ry    <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_abort) begin
                modelBusy <= 1'b0;
            end else if (mul_start) begin
                modelBusy <= 1'b1;
                modelCnt  <= 1;
                mK        <= mul_k;
                mPx       <= mul_px;
                mPy       <= mul_py;
            end else if (modelBusy) begin
                if (modelEnable && modelCnt == modelLatency - 1) begin
                    mul_done  <= 1'b1;
                    mul_rx    <= mK + mPx;
                    mul_ry    <= mK + mPy;
                    modelBusy <= 1'b0;
                end else begin
                    modelCnt <= modelCnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mul_start) begin
            startCount <= startCount + 1;
            lastStart  <= cycle;
        end
        if (mul_abort) begin
            abortCount <= abortCount + 1;
            lastAbort  <= cycle;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [W-1:0] k0, input logic [W-1:0] px0, input logic [W-1:0] py0,
                                 input logic [W-1:0] k1, input logic [W-1:0] px1, input logic [W-1:0] py1);
        req_k[0]  = k0;
        req_px[0] = px0;
        req_py[0] = py0;
        req_k[1]  = k1;
        req_px[1] = px1;
        req_py[1] = py1;
        req_valid = valid;
    endtask

    // Expect a grant, queue the expected result, then cross the handshake edge.
    task automatic handshake(input logic [1:0] expGrant);
        int           waited = 0;
        logic         id;
        logic [W-1:0] k;
        exp_t         e;
        #1;
        while (req_ready == 2'b00 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("req_ready", {30'd0, req_ready}, {30'd0, expGrant});
        id   = expGrant[1];
        k    = req_k[id];
        e.id = id;
        if (modelEnable) begin
            e.rx  = req_k[id] + req_px[id];
            e.ry  = req_k[id] + req_py[id];
            e.err = 1'b0;
        end else begin
            e.rx  = '0;
            e.ry  = '0;
            e.err = 1'b1;
        end
        sb.push_back(e);
        tick();
        req_valid[id] = 1'b0;
        checkOutput("req_ready_busy", {30'd0, req_ready}, 32'd0);
        checkOutput("mul_start", {31'd0, mul_start}, 32'd1);
        checkOutput("mul_k", mul_k, k);
    endtask

    // Wait for the response, compare against the queue head, optionally hold
    // rsp_ready low for a while, then complete the handshake.
    task automatic waitResp(input int expLat, input int hold);
        int         waited = 0;
        exp_t       e;
        logic [1:0] oh;
        logic [1:0] savedValid;
        while (rsp_valid == 2'b00 && waited < 60) begin
            tick();
            waited++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", sb.size());
            return;
        end
        e  = sb.pop_front();
        oh = e.id ? 2'b10 : 2'b01;
        checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        if (expLat > 0) checkOutput("latency", waited, expLat);
        checkOutput("rsp_rx", rsp_rx, e.rx);
        checkOutput("rsp_ry", rsp_ry, e.ry);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        savedValid = req_valid;
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            rsp_ready = ~oh;
            tick();
            checkOutput("hold_rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
            checkOutput("hold_rsp_rx", rsp_rx, e.rx);
            checkOutput("hold_rsp_ry", rsp_ry, e.ry);
            checkOutput("hold_req_ready", {30'd0, req_ready}, 32'd0);
            checkOutput("hold_mul_start", {31'd0, mul_start}, 32'd0);
        end
        req_valid = savedValid;
        rsp_ready = oh;
        tick();
        rsp_ready = 2'b00;
        checkOutput("rsp_valid_drop", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_k     = '0;
        req_px    = '0;
        req_py    = '0;
        tick();
        tick();
        checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rx", rsp_rx, '0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("rst_mul_start", {31'd0, mul_start}, 32'd0);
        checkOutput("rst_mul_abort", {31'd0, mul_abort}, 32'd0);
        checkOutput("rst_mul_k", mul_k, '0);
        rst = 1'b0;
        tick();

        // Contention from reset: r0, then r1, then r0 again on the next tie.
        applyStimulus(2'b11, 10, 3, 4, 20, 7, 9);
        handshake(2'b01);
        waitResp(6, 0);
        handshake(2'b10);
        waitResp(6, 0);
        applyStimulus(2'b11, 1, 1, 1, 2, 2, 2);
        handshake(2'b01);
        req_valid = 2'b00;
        waitResp(6, 0);

        // Lone r0 while the pointer favours r1.
        startBefore = startCount;
        applyStimulus(2'b01, 5, 1, 2, 0, 0, 0);
        handshake(2'b01);
        waitResp(6, 0);
        checkOutput("single_start_count", startCount, startBefore + 1);

        // Multiplier never answers: abort TIMEOUT cycles after start.
        modelEnable = 1'b0;
        abortBefore = abortCount;
        applyStimulus(2'b01, 9, 9, 9, 0, 0, 0);
        handshake(2'b01);
        waitResp(0, 0);
        checkOutput("abort_count", abortCount, abortBefore + 1);
        checkOutput("abort_delay", lastAbort - lastStart, TIMEOUT);
        modelEnable = 1'b1;

        // Done lands on the timeout cycle itself: result wins, no abort.
        modelLatency = TIMEOUT - 1;
        abortBefore  = abortCount;
        applyStimulus(2'b10, 0, 0, 0, 3, 4, 5);
        handshake(2'b10);
        waitResp(TIMEOUT, 0);
        checkOutput("late_done_no_abort", abortCount, abortBefore);
        modelLatency = 5;

        // Backpressure for 10 cycles with both requesters pushing.
        startBefore = startCount;
        applyStimulus(2'b01, 100, 1, 2, 0, 0, 0);
        handshake(2'b01);
        waitResp(6, 10);
        checkOutput("bp_start_count", startCount, startBefore + 1);

        // Reset mid-operation drops it silently and rewinds the pointer.
        abortBefore = abortCount;
        applyStimulus(2'b01, 50, 1, 1, 0, 0, 0);
        handshake(2'b01);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("wrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("wrst_mul_start", {31'd0, mul_start}, 32'd0);
        checkOutput("wrst_mul_abort", {31'd0, mul_abort}, 32'd0);
        checkOutput("wrst_mul_k", mul_k, '0);
        checkOutput("wrst_rsp_rx", rsp_rx, '0);
        checkOutput("wrst_req_ready", {30'd0, req_ready}, 32'd0);
        rst = 1'b0;
        sb.delete();
        tick();
        checkOutput("wrst_abort_count", abortCount, abortBefore);
        applyStimulus(2'b11, 7, 8, 9, 4, 4, 4);
        handshake(2'b01);
        waitResp(6, 0);
        handshake(2'b10);
        waitResp(6, 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
